// File: rtl/event_counter.sv
// Purpose: counts rising edges of an asynchronous event line, up or down, with wrap or saturate at 0..MAX.
// Latency: evt_in rising before edge N updates value at edge N+SYNC_STAGES; carry is registered alongside value.
// Backpressure: none; events arriving with en=0 or coinciding with clear/load are dropped, not queued.
module event_counter #(
    parameter int              WIDTH       = 8,
    parameter longint unsigned MAX         = (64'd1 << WIDTH) - 64'd1,
    parameter bit              SATURATE    = 1'b0,
    parameter int              SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             evt_in,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             carry,
    output logic             at_max,
    output logic             at_zero
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sev_d_q, sev_d_d;
    logic [WIDTH-1:0]       value_q, value_d;
    logic                   carry_q, carry_d;
    logic                   sev;
    logic                   step;

    // Shift the raw event line into the synchroniser; the last stage is the synchronised event.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], evt_in};
        sev_d_d = sev;
    end

    assign sev  = sync_q[SYNC_STAGES-1];
    // One-cycle step on each low-to-high transition of the synchronised event.
    assign step = sev & ~sev_d_q;

    // Next count: clear beats load beats an enabled step; carry flags a step that hit a bound.
    always_comb begin
        value_d = value_q;
        carry_d = 1'b0;
        if (clear) begin
            value_d = '0;
        end else if (load) begin
            value_d = (load_value > MAX_V) ? MAX_V : load_value;
        end else if (step && en) begin
            if (up) begin
                if (value_q == MAX_V) begin
                    value_d = SATURATE ? MAX_V : '0;
                    carry_d = 1'b1;
                end else begin
                    value_d = value_q + 1'b1;
                end
            end else begin
                if (value_q == '0) begin
                    value_d = SATURATE ? '0 : MAX_V;
                    carry_d = 1'b1;
                end else begin
                    value_d = value_q - 1'b1;
                end
            end
        end
    end

    // All state, including the synchroniser, returns to zero on reset so an in-flight edge is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            sev_d_q <= 1'b0;
            value_q <= '0;
            carry_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            sev_d_q <= sev_d_d;
            value_q <= value_d;
            carry_q <= carry_d;
        end
    end

    assign value   = value_q;
    assign carry   = carry_q;
    assign at_max  = (value_q == MAX_V);
    assign at_zero = (value_q == '0);

endmodule

// File: tb/tb_event_counter.sv
// Purpose: directed bench for event_counter across wrap, saturate and clamp configurations.
// Latency: each event is a 3-cycle-high / 3-cycle-low pulse; results are read 1 time unit after a clock edge.
// Backpressure: not applicable.
module tb_event_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       evt_in;
    logic       en;
    logic       up;
    logic       clear;
    logic       load;
    logic [7:0] lv;

    logic [7:0] v0, v3;
    logic [3:0] v1, v2;
    logic       c0, c1, c2, c3;
    logic       m0, m1, m2, m3;
    logic       z0, z1, z2, z3;

    int total = 0;
    int bad   = 0;
    int cc0 = 0, cc1 = 0, cc2 = 0, cc3 = 0;

    always #5 clk = ~clk;

    // u0: full 8-bit wrap; u1: MAX=9 wrap; u2: MAX=9 saturate; u3: MAX=99 wrap for load clamping.
    event_counter #(.WIDTH(8), .SATURATE(1'b0), .SYNC_STAGES(2)) u0 (
        .clk(clk), .reset(reset), .evt_in(evt_in), .en(en), .up(up), .clear(clear),
        .load(load), .load_value(lv), .value(v0), .carry(c0), .at_max(m0), .at_zero(z0));
    event_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0), .SYNC_STAGES(2)) u1 (
        .clk(clk), .reset(reset), .evt_in(evt_in), .en(en), .up(up), .clear(clear),
        .load(load), .load_value(lv[3:0]), .value(v1), .carry(c1), .at_max(m1), .at_zero(z1));
    event_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b1), .SYNC_STAGES(2)) u2 (
        .clk(clk), .reset(reset), .evt_in(evt_in), .en(en), .up(up), .clear(clear),
        .load(load), .load_value(lv[3:0]), .value(v2), .carry(c2), .at_max(m2), .at_zero(z2));
    event_counter #(.WIDTH(8), .MAX(99), .SATURATE(1'b0), .SYNC_STAGES(2)) u3 (
        .clk(clk), .reset(reset), .evt_in(evt_in), .en(en), .up(up), .clear(clear),
        .load(load), .load_value(lv), .value(v3), .carry(c3), .at_max(m3), .at_zero(z3));

    // Count cycles with carry high per instance, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            cc0 <= 0; cc1 <= 0; cc2 <= 0; cc3 <= 0;
        end else begin
            cc0 <= cc0 + int'(c0);
            cc1 <= cc1 + int'(c1);
            cc2 <= cc2 + int'(c2);
            cc3 <= cc3 + int'(c3);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        evt_in = 1'b1;
        tick(3);
        evt_in = 1'b0;
        tick(3);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic do_load(input logic [7:0] val);
        lv   = val;
        load = 1'b1;
        tick(1);
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; evt_in = 1'b0; en = 1'b1; up = 1'b1;
        clear = 1'b0; load = 1'b0; lv = 8'd0;
        tick(1);
        do_reset();

        // Reset state.
        chk("rst_value", 32'(v0), 0);
        chk("rst_carry", 32'(c0), 0);
        chk("rst_at_zero", 32'(z0), 1);
        chk("rst_at_max", 32'(m0), 0);

        // Five up events; first one checks the two-edge latency.
        evt_in = 1'b1;
        tick(1);
        chk("lat_edge_n", 32'(v0), 0);
        tick(1);
        chk("lat_edge_n1", 32'(v0), 0);
        tick(1);
        chk("lat_edge_n2", 32'(v0), 1);
        evt_in = 1'b0;
        tick(3);
        repeat (4) pulse();
        chk("count5_value", 32'(v0), 5);
        chk("count5_no_carry", 32'(cc0), 0);

        // Wrap mode, MAX=9.
        do_reset();
        do_load(8'd9);
        chk("wrap_load9", 32'(v1), 9);
        chk("wrap_at_max", 32'(m1), 1);
        up = 1'b1;
        pulse();
        chk("wrap_up_value", 32'(v1), 0);
        chk("wrap_up_carry", 32'(cc1), 1);
        up = 1'b0;
        pulse();
        chk("wrap_dn_value", 32'(v1), 9);
        chk("wrap_dn_carry", 32'(cc1), 2);

        // Saturate mode, MAX=9.
        do_reset();
        do_load(8'd9);
        up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pulse();
            chk("sat_up_value", 32'(v2), 9);
            chk("sat_up_carry", 32'(cc2), i + 1);
        end
        do_load(8'd0);
        up = 1'b0;
        pulse();
        chk("sat_dn_value", 32'(v2), 0);
        chk("sat_dn_carry", 32'(cc2), 4);
        chk("sat_dn_at_zero", 32'(z2), 1);

        // Load clamping and load-over-step priority, MAX=99.
        do_reset();
        up = 1'b1;
        do_load(8'd200);
        chk("clamp_value", 32'(v3), 99);
        chk("clamp_at_max", 32'(m3), 1);
        lv = 8'd40;
        evt_in = 1'b1;
        tick(2);
        load = 1'b1;
        tick(1);
        load = 1'b0;
        chk("load_step_value", 32'(v3), 40);
        evt_in = 1'b0;
        tick(3);
        chk("load_step_after", 32'(v3), 40);
        chk("load_step_carry", 32'(cc3), 0);

        // Enable gating and clear.
        do_reset();
        up = 1'b1;
        do_load(8'd3);
        en = 1'b0;
        repeat (4) pulse();
        chk("en0_value", 32'(v0), 3);
        en = 1'b1;
        repeat (2) pulse();
        chk("en1_value", 32'(v0), 5);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("clear_value", 32'(v0), 0);
        pulse();
        chk("clear_then_evt", 32'(v0), 1);

        // Reset while an edge is in the synchroniser drops it.
        do_reset();
        evt_in = 1'b1;
        tick(1);
        reset = 1'b1;
        tick(1);
        evt_in = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(6);
        chk("rst_inflight_value", 32'(v0), 0);
        chk("rst_inflight_carry", 32'(cc0), 0);

        // evt_in held high across reset release gives exactly one step.
        evt_in = 1'b1;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(6);
        chk("held_hi_step", 32'(v0), 1);
        tick(6);
        chk("held_hi_once", 32'(v0), 1);
        evt_in = 1'b0;
        tick(4);
        chk("held_hi_fall", 32'(v0), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/event_counter.md
EVENT_COUNTER -- requirements
Module: event_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits (legal 2..32).
REQ-002 Parameter MAX, default 2**WIDTH-1, highest count value (legal 1..2**WIDTH-1).
REQ-003 Parameter SATURATE, default 0; 0 = wrap at bounds, 1 = hold at bounds.
REQ-004 Parameter SYNC_STAGES, default 2, synchroniser depth for evt_in (legal 2..4).
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 evt_in  input  1  asynchronous event line; each rising edge is one count event.
REQ-008 en  input  1  count enable, sampled at the cycle a synchronised event edge is detected.
REQ-009 up  input  1  direction; 1 = increment, 0 = decrement.
REQ-010 clear  input  1  synchronous clear of value to 0.
REQ-011 load  input  1  synchronous load of load_value.
REQ-012 load_value  input  WIDTH  value to load.
REQ-013 value  output  WIDTH  registered current count.
REQ-014 carry  output  1  registered one-cycle pulse on wrap or saturation.
REQ-015 at_max  output  1  combinational, 1 when value == MAX.
REQ-016 at_zero  output  1  combinational, 1 when value == 0.

Function
REQ-017 evt_in SHALL pass through a SYNC_STAGES-deep flop chain; its output is the synchronised event (sev).
REQ-018 A one-flop delayed copy of sev SHALL drive edge detect: step = sev & ~sev_d; step is high for exactly one cycle per evt_in rising edge.
REQ-019 Latency: evt_in high before rising edge N, held >= SYNC_STAGES+1 cycles -> value updated at edge N+SYNC_STAGES.
REQ-020 evt_in pulses shorter than one clk period are not guaranteed to be counted; pulses high and low >= 2 clk periods each are counted exactly once each.
REQ-021 Per-cycle priority, highest first: reset, clear, load, step&en; otherwise value holds.
REQ-022 clear: value <= 0, carry <= 0, synchroniser and edge-detect state unaffected.
REQ-023 load: value <= min(load_value, MAX), carry <= 0; a step in the same cycle is discarded.
REQ-024 step&en&up, value < MAX: value <= value+1, carry <= 0.
REQ-025 step&en&up, value == MAX: SATURATE=0 -> value <= 0; SATURATE=1 -> value holds MAX; carry <= 1 in both modes.
REQ-026 step&en&~up, value > 0: value <= value-1, carry <= 0.
REQ-027 step&en&~up, value == 0: SATURATE=0 -> value <= MAX; SATURATE=1 -> value holds 0; carry <= 1 in both modes.
REQ-028 step with en=0: event discarded, value holds, carry <= 0.
REQ-029 carry SHALL be 0 in every cycle not covered by REQ-025/REQ-027.
REQ-030 Arithmetic is modulo MAX+1 in wrap mode; no intermediate value outside 0..MAX appears on value.
REQ-031 up or en changing between events SHALL affect only steps detected after the change.

Reset
REQ-032 On reset: value = 0, carry = 0, all synchroniser flops and sev_d = 0.
REQ-033 evt_in already high when reset deasserts SHALL produce one step once the synchroniser fills (rising edge from reset-0 state).
REQ-034 reset asserted while an event is in the synchroniser SHALL discard that event.

Verification
REQ-035 WIDTH=8, MAX=255, SATURATE=0; reset, 5 evt_in pulses, up=1, en=1 -> value=5, carry never high, value changes SYNC_STAGES cycles after each edge.
REQ-036 MAX=9, SATURATE=0; load 9, one up event -> value=0, carry high 1 cycle; one down event -> value=9, carry high 1 cycle.
REQ-037 MAX=9, SATURATE=1; load 9, three up events -> value stays 9, carry pulses 3 times; load 0, down event -> value 0, carry pulse.
REQ-038 load_value=200 with MAX=99 -> value=99, at_max=1; load and step same cycle -> value = loaded value only.
REQ-039 en=0 during 4 events, then en=1 for 2 events from value=3 -> value=5; clear asserted mid-stream -> value=0 next cycle, following event counts to 1.
REQ-040 Reset asserted 1 cycle after evt_in rises -> value=0 after reset, no step from that edge; evt_in held high through reset release -> exactly one step.
